sram_like_mem_responder: RTL and testbench
==========================================

# sram_like_mem_responder

Responder (slave) end of the sram-like handshake used between the MIPS core adapters and the memory side. It accepts requests on the req/addr_ok channel and returns in-order responses on the data_ok channel after a fixed, parameterised latency, backed by an internal word-organised RAM. It serves as a drop-in instruction or data memory behind `i_sram_to_sram_like`/`d_sram_to_sram_like`, for core bring-up and adapter verification without the AXI bridge.

## Interface
- `ADDR_W`, 12: word-address bits; RAM holds 2^ADDR_W 32-bit words.
- `LATENCY`, 2: cycles from request acceptance to its data_ok; legal range 1..8.
- `MAX_OUT`, 2: maximum outstanding (accepted, not yet responded) requests; legal range 1..8.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  request valid.
- `wr`  in  1  1 = write, 0 = read.
- `size`  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data, byte lanes aligned to addr[1:0].
- `stall_in`  in  1  backpressure injection; forces addr_ok low.
- `addr_ok`  out  1  request accepted this cycle when high with req.
- `data_ok`  out  1  one response completes this cycle.
- `rdata`  out  32  read word for the completing read.
- `err`  out  1  sticky misaligned/illegal-access flag.

## Operation
- Acceptance: handshake when `req && addr_ok` at a rising edge. `addr_ok = !rst && !stall_in && (outstanding < MAX_OUT)`; `outstanding` is the registered count, so a retire in the same cycle does not free a slot until the next cycle.
- Word index = addr[ADDR_W+1:2]; higher address bits ignored (aliasing).
- Writes execute into RAM at the acceptance edge. Byte enables: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<addr[1:0]; size 2 -> 4'b1111. Little-endian; only enabled lanes of `wdata` are stored.
- Reads sample the RAM at the acceptance edge, after any write accepted in earlier cycles; full 32-bit word returned (master extracts bytes).
- Misaligned (size 1 with addr[0]=1; size 2 with addr[1:0]!=0) or size 3: still accepted and responded; write suppressed; read returns the addressed word; `err` set and held until reset.
- Response queue: MAX_OUT entries each holding {is_read, data, countdown}; responses retire strictly in acceptance order, one per cycle maximum.
- Simultaneous accept and retire: `outstanding` unchanged; both take effect.
- RAM contents are not reset; zero-initialised at simulation start.

## Timing
- Request accepted at edge E -> `data_ok` high for exactly the cycle following edge E+LATENCY-1 (LATENCY=1: the cycle right after acceptance).
- Back-to-back accepts produce back-to-back `data_ok` pulses; full throughput requires MAX_OUT >= LATENCY, otherwise addr_ok drops periodically.
- `data_ok`, `rdata` registered. `rdata` = read word while data_ok high on a read; 32'h0 on write responses and when data_ok low.
- `addr_ok` combinational from `stall_in`, `rst`, `outstanding`; it does not depend on `req`.
- Reset values (cycle after rst edge): data_ok 0, rdata 0, err 0, outstanding 0; addr_ok 0 while rst high.
- Reset mid-operation: all outstanding requests discarded, no data_ok for them after reset; writes accepted before reset remain in RAM.
- `stall_in` during outstanding requests: responses still retire on schedule; only acceptance stops.

## Test plan
- LATENCY=2: write word 0xDEADBEEF to 0x100, then read 0x100 -> write data_ok 2 cycles after its accept with rdata 0; read data_ok 2 cycles after accept with rdata 0xDEADBEEF.
- Byte/half writes: word 0x00000000 at 0x40; byte 0xAA to 0x41, half 0x1234 to 0x42 -> read 0x40 returns 0x1234AA00.
- LATENCY=3, MAX_OUT=4, five reads held on req -> five consecutive addr_ok, five consecutive data_ok starting 3 cycles after first accept, data in order.
- LATENCY=4, MAX_OUT=2, continuous req -> addr_ok high 2 cycles, low until first retire registers, outstanding never exceeds 2.
- Misaligned word write to 0x102 with 0xFFFFFFFF -> accepted, data_ok returned, word at 0x100 unchanged, err=1 until rst.
- Two reads outstanding, rst pulsed one cycle -> no data_ok afterward, addr_ok low during rst and high next cycle; subsequent read returns data written before reset.

Source files
------------

// File: rtl/sram_like_if.sv
// sram-like request/response channel between a requesting master and a memory responder.
interface sram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall_in;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wdata, stall_in,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wdata, stall_in,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/sram_like_mem_responder.sv
// Fixed-latency, in-order sram-like memory responder backed by a word-organised RAM.
// Each accepted request travels a LATENCY-deep response line and completes as data_ok.
module sram_like_mem_responder #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    sram_like_if.slave  bus
);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);
    localparam int unsigned PIPE_D = (LATENCY > 1) ? LATENCY - 1 : 1;

    typedef struct packed {
        logic        valid;
        logic        is_read;
        logic [31:0] data;
    } resp_t;

    logic [31:0]       mem [DEPTH];
    logic [CNT_W-1:0]  outstanding;
    resp_t             pipe [PIPE_D];
    resp_t             line [LATENCY];
    logic [ADDR_W-1:0] word_idx;
    logic [3:0]        be;
    logic              misaligned;
    logic              accept;
    logic              retire;
    logic              unused_addr;

    assign word_idx    = bus.addr[ADDR_W+1:2];
    assign unused_addr = &{1'b0, bus.addr[31:ADDR_W+2]};

    assign bus.addr_ok = !rst && !bus.stall_in && (outstanding < CNT_W'(MAX_OUT));
    assign accept      = bus.req && bus.addr_ok;

    // Byte-lane decode and alignment check for the current request.
    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        case (bus.size)
            2'd0: be = 4'b0001 << bus.addr[1:0];
            2'd1: begin
                be         = 4'b0011 << bus.addr[1:0];
                misaligned = bus.addr[0];
            end
            2'd2: begin
                be         = 4'b1111;
                misaligned = (bus.addr[1:0] != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    // line[0] is the request being accepted now; later slots are registered stages.
    always_comb begin
        line[0].valid   = accept;
        line[0].is_read = !bus.wr;
        line[0].data    = mem[word_idx];
        for (int k = 1; k < int'(LATENCY); k++) begin
            line[k] = pipe[k-1];
        end
    end

    assign retire = line[LATENCY-1].valid;

    // RAM is deliberately not reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (accept && bus.wr && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            bus.data_ok <= 1'b0;
            bus.rdata   <= '0;
            bus.err     <= 1'b0;
            for (int k = 0; k < int'(PIPE_D); k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= line[0];
            for (int k = 1; k < int'(PIPE_D); k++) begin
                pipe[k] <= pipe[k-1];
            end
            // A request retiring at the same edge it would be counted leaves the count as is.
            case ({accept, retire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            bus.data_ok <= retire;
            bus.rdata   <= (retire && line[LATENCY-1].is_read) ? line[LATENCY-1].data : 32'h0;
            if (accept && misaligned) begin
                bus.err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Randomised bench for sram_like_mem_responder against a queue-based reference model.
module tb_sram_like_mem_responder;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned MAX_OUT = 2;

    typedef struct {
        int          due;
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    sram_like_if bus ();

    sram_like_mem_responder #(
        .ADDR_W (ADDR_W),
        .LATENCY(LATENCY),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    logic        last_acc;
    logic        exp_err;
    logic        exp_dok;
    logic [31:0] exp_rd;
    logic [31:0] mem_m [1 << ADDR_W];
    exp_t        pend [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_n, got, exp);
        end
    endtask

    function automatic logic lane_on(input logic [1:0] s, input logic [1:0] off, input int lane);
        if (s == 2'd2) return 1'b1;
        if (s == 2'd0) return lane == int'(off);
        if (s == 2'd1) return (lane == int'(off)) || (lane == int'(off) + 1);
        return 1'b0;
    endfunction

    // One clock: drive, check addr_ok, advance model at the edge, check registered outputs.
    task automatic cycle(input logic r, input logic q, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d, input logic st);
        logic exp_ok;
        logic mis;
        int   idx;
        exp_t e;
        rst          = r;
        bus.req      = q;
        bus.wr       = w;
        bus.size     = s;
        bus.addr     = a;
        bus.wdata    = d;
        bus.stall_in = st;
        #1;
        exp_ok = !r && !st && (pend.size() < int'(MAX_OUT));
        check("addr_ok", 32'(bus.addr_ok), 32'(exp_ok));
        last_acc = q && exp_ok;
        @(posedge clk);
        edge_n++;
        exp_dok = 1'b0;
        exp_rd  = 32'h0;
        if (r) begin
            pend.delete();
            exp_err = 1'b0;
        end else begin
            if (last_acc) begin
                mis = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
                idx = int'(a[ADDR_W+1:2]);
                if (mis) exp_err = 1'b1;
                if (w && !mis) begin
                    for (int i = 0; i < 4; i++) begin
                        if (lane_on(s, a[1:0], i)) mem_m[idx][8*i +: 8] = d[8*i +: 8];
                    end
                end
                e.due     = edge_n + int'(LATENCY) - 1;
                e.is_read = !w;
                e.data    = w ? 32'h0 : mem_m[idx];
                pend.push_back(e);
            end
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                exp_dok = 1'b1;
                exp_rd  = pend[0].data;
                void'(pend.pop_front());
            end
        end
        @(negedge clk);
        check("data_ok", 32'(bus.data_ok), 32'(exp_dok));
        check("rdata", bus.rdata, exp_rd);
        check("err", 32'(bus.err), 32'(exp_err));
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        do begin
            cycle(1'b0, 1'b1, w, s, a, d, 1'b0);
            n++;
        end while (!last_acc && n < 50);
        check("accept_bound", 32'(last_acc), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic        r;
        logic        q;
        logic        w;
        logic        st;
        logic [1:0]  s;
        logic [1:0]  off;
        logic [31:0] hi;
        logic [31:0] a;
        int          idx;

        for (int i = 0; i < (1 << ADDR_W); i++) mem_m[i] = 32'h0;
        exp_err = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);

        // Give every word the bench touches a known value.
        for (int i = 0; i <= 16; i++) issue(1'b1, 2'd2, 32'(i * 4), 32'h0);
        issue(1'b1, 2'd2, 32'h100, 32'h0);
        idle(4);

        issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        idle(4);

        issue(1'b1, 2'd0, 32'h41, 32'h0000AA00);
        issue(1'b1, 2'd1, 32'h42, 32'h12340000);
        issue(1'b0, 2'd2, 32'h40, 32'h0);
        idle(4);
        check("byte_half_merge", mem_m[16], 32'h1234AA00);

        for (int i = 0; i < 5; i++) issue(1'b0, 2'd2, 32'(i * 4), 32'h0);
        idle(4);

        // Responses keep retiring while acceptance is stalled.
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h4, 32'h0, 1'b1);
        idle(2);

        issue(1'b1, 2'd2, 32'h102, 32'hFFFFFFFF);
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        idle(4);

        issue(1'b0, 2'd2, 32'h100, 32'h0);
        issue(1'b0, 2'd2, 32'h40, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 1'b0);
        idle(5);
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        idle(4);

        for (int n = 0; n < 2000; n++) begin
            r   = ($urandom_range(99) == 0);
            q   = ($urandom_range(99) < 70);
            w   = 1'($urandom_range(1));
            st  = ($urandom_range(99) < 15);
            idx = $urandom_range(15);
            hi  = $urandom;
            if ($urandom_range(99) < 3) begin
                s   = 2'($urandom_range(3));
                off = 2'($urandom_range(3));
            end else begin
                s = 2'($urandom_range(2));
                case (s)
                    2'd0:    off = 2'($urandom_range(3));
                    2'd1:    off = {1'($urandom_range(1)), 1'b0};
                    default: off = 2'b00;
                endcase
            end
            a = {hi[31:14], 8'h00, 4'(idx), off};
            cycle(r, q, w, s, a, $urandom, st);
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
